// File: rtl/sha1_work_dispatcher.sv
// sha1_work_dispatcher
//
// Hash-clock-domain work dispatcher. Latches each job delivered by the JTAG
// communication block and streams base nonces to the SHA-1 core array over
// a valid/ready handshake. Results coming back from the core array are
// filtered by job tag. The first matching nonce of the current job is held
// for host readback.
//
// Ports:
//   hash_clk           sole clock
//   reset              synchronous, active-high reset
//   new_work           one-cycle pulse, job fields valid in the same cycle
//   fixed_data         job fixed message bits (56)
//   target_hash        job target digest (160)
//   start_nonce        first nonce of the job (60)
//   core_valid         request valid towards the core array
//   core_ready         core array accepts the request
//   core_nonce         base nonce of the current request (60)
//   core_tag           job tag carried with the request (TAG_W)
//   core_fixed_data    latched fixed_data
//   core_target_hash   latched target_hash
//   res_valid          result strobe from the core array
//   res_match          result digest equals the target
//   res_nonce          nonce that produced the result (60)
//   res_tag            job tag returned with the result (TAG_W)
//   golden_nonce_found sticky found flag for the current job
//   golden_nonce       first matching nonce of the current job
//   busy               high while requests are being issued
//   exhausted          nonce space wrapped before a stop-on-find termination
//   issued_count       accepted requests this job, wraps modulo 2^32

module sha1_work_dispatcher #(
    parameter int NONCE_STEP   = 1,
    parameter int TAG_W        = 2,
    parameter bit STOP_ON_FIND = 1'b1
) (
    input  logic               hash_clk,
    input  logic               reset,
    input  logic               new_work,
    input  logic [55:0]        fixed_data,
    input  logic [159:0]       target_hash,
    input  logic [59:0]        start_nonce,
    output logic               core_valid,
    input  logic               core_ready,
    output logic [59:0]        core_nonce,
    output logic [TAG_W-1:0]   core_tag,
    output logic [55:0]        core_fixed_data,
    output logic [159:0]       core_target_hash,
    input  logic               res_valid,
    input  logic               res_match,
    input  logic [59:0]        res_nonce,
    input  logic [TAG_W-1:0]   res_tag,
    output logic               golden_nonce_found,
    output logic [59:0]        golden_nonce,
    output logic               busy,
    output logic               exhausted,
    output logic [31:0]        issued_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [60:0] nonce_sum;
    logic        request_fire;
    logic        result_accept;

    // Handshake, result filter and next-state decode. The nonce sum is one
    // bit wider than the nonce so that bit 60 flags a wrap of the nonce
    // space; the wrapped value is never presented as a valid request.
    // core_tag doubles as the internal job tag, so the result filter
    // compares against it directly. A new job always wins over a result
    // arriving in the same cycle, since that result belongs to the old job.
    always_comb begin
        nonce_sum     = {1'b0, core_nonce} + 61'(NONCE_STEP);
        request_fire  = core_valid & core_ready;
        result_accept = res_valid & res_match & (res_tag == core_tag)
                        & ~golden_nonce_found & ~new_work;
        state_next    = state;
        if (new_work) begin
            state_next = RUN;
        end else begin
            if (request_fire && nonce_sum[60]) begin
                state_next = DONE;
            end
            if (result_accept && STOP_ON_FIND && (state == RUN)) begin
                state_next = DONE;
            end
        end
    end

    // Job, request and result registers. core_valid and busy are registered
    // copies of "next state is RUN" so they line up with the state register.
    // A request accepted in the same cycle as a stopping hit still advances
    // the nonce and the issue counter, because the core array has taken it.
    // Results are still accepted in IDLE and DONE so that hits in flight at
    // exhaustion are not lost.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state              <= IDLE;
            core_valid         <= 1'b0;
            busy               <= 1'b0;
            core_nonce         <= '0;
            core_tag           <= '0;
            core_fixed_data    <= '0;
            core_target_hash   <= '0;
            golden_nonce_found <= 1'b0;
            golden_nonce       <= '0;
            exhausted          <= 1'b0;
            issued_count       <= '0;
        end else begin
            state      <= state_next;
            core_valid <= (state_next == RUN);
            busy       <= (state_next == RUN);
            if (new_work) begin
                core_fixed_data    <= fixed_data;
                core_target_hash   <= target_hash;
                core_nonce         <= start_nonce;
                core_tag           <= core_tag + TAG_W'(1);
                golden_nonce_found <= 1'b0;
                golden_nonce       <= '0;
                exhausted          <= 1'b0;
                issued_count       <= '0;
            end else begin
                if (request_fire) begin
                    core_nonce   <= nonce_sum[59:0];
                    issued_count <= issued_count + 32'd1;
                    if (nonce_sum[60]) begin
                        exhausted <= 1'b1;
                    end
                end
                if (result_accept) begin
                    golden_nonce       <= res_nonce;
                    golden_nonce_found <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha1_work_dispatcher.sv
// tb_sha1_work_dispatcher
//
// Self-checking bench for sha1_work_dispatcher. The main instance uses
// NONCE_STEP=1 and is tracked cycle by cycle by a job-level reference model;
// a second instance with NONCE_STEP=4 covers the nonce-space wrap case.

module tb_sha1_work_dispatcher;

    localparam int TAG_W     = 2;
    localparam int MAIN_STEP = 1;
    localparam logic [63:0] NONCE_SPACE = 64'h1000_0000_0000_0000;

    logic         hash_clk;
    logic         reset;
    logic         new_work;
    logic [55:0]  fixed_data;
    logic [159:0] target_hash;
    logic [59:0]  start_nonce;
    logic         core_ready;
    logic         res_valid;
    logic         res_match;
    logic [59:0]  res_nonce;
    logic [1:0]   res_tag;

    logic         core_valid;
    logic [59:0]  core_nonce;
    logic [1:0]   core_tag;
    logic [55:0]  core_fixed_data;
    logic [159:0] core_target_hash;
    logic         golden_nonce_found;
    logic [59:0]  golden_nonce;
    logic         busy;
    logic         exhausted;
    logic [31:0]  issued_count;

    logic         new_work4;
    logic [59:0]  start_nonce4;
    logic         core_ready4;
    logic         core_valid4;
    logic [59:0]  core_nonce4;
    logic [1:0]   core_tag4;
    logic [55:0]  core_fixed_data4;
    logic [159:0] core_target_hash4;
    logic         golden_nonce_found4;
    logic [59:0]  golden_nonce4;
    logic         busy4;
    logic         exhausted4;
    logic [31:0]  issued_count4;

    int checks;
    int failures;

    // Reference model of the current job
    bit           m_run;
    logic [59:0]  m_nonce;
    logic [1:0]   m_tag;
    logic [55:0]  m_fixed;
    logic [159:0] m_target;
    bit           m_found;
    logic [59:0]  m_golden;
    bit           m_exh;
    logic [31:0]  m_count;

    logic [373:0] obs_vec;
    assign obs_vec = {core_valid, core_nonce, core_tag, core_fixed_data,
                      core_target_hash, golden_nonce_found, golden_nonce,
                      busy, exhausted, issued_count};

    sha1_work_dispatcher #(
        .NONCE_STEP  (MAIN_STEP),
        .TAG_W       (TAG_W),
        .STOP_ON_FIND(1'b1)
    ) dut (
        .hash_clk          (hash_clk),
        .reset             (reset),
        .new_work          (new_work),
        .fixed_data        (fixed_data),
        .target_hash       (target_hash),
        .start_nonce       (start_nonce),
        .core_valid        (core_valid),
        .core_ready        (core_ready),
        .core_nonce        (core_nonce),
        .core_tag          (core_tag),
        .core_fixed_data   (core_fixed_data),
        .core_target_hash  (core_target_hash),
        .res_valid         (res_valid),
        .res_match         (res_match),
        .res_nonce         (res_nonce),
        .res_tag           (res_tag),
        .golden_nonce_found(golden_nonce_found),
        .golden_nonce      (golden_nonce),
        .busy              (busy),
        .exhausted         (exhausted),
        .issued_count      (issued_count)
    );

    sha1_work_dispatcher #(
        .NONCE_STEP  (4),
        .TAG_W       (TAG_W),
        .STOP_ON_FIND(1'b1)
    ) dut4 (
        .hash_clk          (hash_clk),
        .reset             (reset),
        .new_work          (new_work4),
        .fixed_data        (fixed_data),
        .target_hash       (target_hash),
        .start_nonce       (start_nonce4),
        .core_valid        (core_valid4),
        .core_ready        (core_ready4),
        .core_nonce        (core_nonce4),
        .core_tag          (core_tag4),
        .core_fixed_data   (core_fixed_data4),
        .core_target_hash  (core_target_hash4),
        .res_valid         (1'b0),
        .res_match         (1'b0),
        .res_nonce         (60'd0),
        .res_tag           (2'd0),
        .golden_nonce_found(golden_nonce_found4),
        .golden_nonce      (golden_nonce4),
        .busy              (busy4),
        .exhausted         (exhausted4),
        .issued_count      (issued_count4)
    );

    // Free-running hash clock
    initial begin
        hash_clk = 1'b0;
        forever #5 hash_clk = ~hash_clk;
    end

    function automatic logic [59:0] rand60();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[59:0];
    endfunction

    function automatic logic [55:0] rand56();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[55:0];
    endfunction

    function automatic logic [373:0] exp_vec();
        return {m_run, m_nonce, m_tag, m_fixed, m_target, m_found, m_golden,
                m_run, m_exh, m_count};
    endfunction

    // Job-level behaviour: a new job restarts everything, an accepted
    // request moves to the next nonce and ends the job if the nonce space
    // is used up, the first matching result of this job is kept.
    task automatic model_update();
        logic [63:0] next_n;
        bit          was_run;
        if (reset) begin
            m_run = 0; m_nonce = '0; m_tag = '0; m_fixed = '0; m_target = '0;
            m_found = 0; m_golden = '0; m_exh = 0; m_count = '0;
        end else if (new_work) begin
            m_run = 1; m_nonce = start_nonce; m_tag = m_tag + 2'd1;
            m_fixed = fixed_data; m_target = target_hash;
            m_found = 0; m_golden = '0; m_exh = 0; m_count = '0;
        end else begin
            was_run = m_run;
            if (was_run && core_ready) begin
                next_n  = {4'b0, m_nonce} + 64'(MAIN_STEP);
                m_count = m_count + 32'd1;
                if (next_n >= NONCE_SPACE) begin
                    m_exh = 1;
                    m_run = 0;
                end
                m_nonce = next_n[59:0];
            end
            if (res_valid && res_match && (res_tag == m_tag) && !m_found) begin
                m_golden = res_nonce;
                m_found  = 1;
                if (was_run) m_run = 0;
            end
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled there too
    task automatic tick();
        @(posedge hash_clk);
        model_update();
        @(negedge hash_clk);
    endtask

    task automatic set_idle();
        new_work = 0; core_ready = 0; res_valid = 0; res_match = 0;
        res_nonce = '0; res_tag = '0; new_work4 = 0; core_ready4 = 0;
    endtask

    task automatic start_job(input logic [59:0] nonce);
        new_work    = 1;
        start_nonce = nonce;
        fixed_data  = rand56();
        target_hash = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic test_reset();
        set_idle();
        start_nonce = '0; start_nonce4 = '0; fixed_data = '0; target_hash = '0;
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (obs_vec !== '0) begin
            failures++;
            $display("[TB] FAIL reset_zero: got %h expected 0", obs_vec);
        end
        checks++;
        if (obs_vec !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL reset_model: got %h expected %h", obs_vec, exp_vec());
        end
        checks++;
        if ({core_valid4, issued_count4, core_tag4} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_dut4: got %b/%0d/%0d expected 0", core_valid4, issued_count4, core_tag4);
        end
    endtask

    task automatic test_sequence();
        logic [55:0] fd;
        start_job(60'h10);
        fd = fixed_data;
        core_ready = 1;
        tick();
        new_work = 0;
        checks++;
        if ({core_valid, core_nonce, core_tag, issued_count} !== {1'b1, 60'h10, 2'd1, 32'd0}) begin
            failures++;
            $display("[TB] FAIL seq_first: got v=%b n=%h t=%0d c=%0d expected v=1 n=10 t=1 c=0",
                     core_valid, core_nonce, core_tag, issued_count);
        end
        checks++;
        if (core_fixed_data !== fd) begin
            failures++;
            $display("[TB] FAIL seq_fixed: got %h expected %h", core_fixed_data, fd);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (core_nonce !== 60'h10 + 60'(i) || issued_count !== 32'(i)) begin
                failures++;
                $display("[TB] FAIL seq_step%0d: got n=%h c=%0d expected n=%h c=%0d",
                         i, core_nonce, issued_count, 60'h10 + 60'(i), i);
            end
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL seq_model%0d: got %h expected %h", i, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_stall();
        logic [59:0] held_n;
        logic [31:0] held_c;
        held_n = m_nonce;
        held_c = m_count;
        core_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (core_nonce !== held_n || issued_count !== held_c || core_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL stall%0d: got n=%h c=%0d v=%b expected n=%h c=%0d v=1",
                         i, core_nonce, issued_count, core_valid, held_n, held_c);
            end
        end
        core_ready = 1;
        tick();
        checks++;
        if (core_nonce !== held_n + 60'd1 || issued_count !== held_c + 32'd1) begin
            failures++;
            $display("[TB] FAIL stall_resume: got n=%h c=%0d expected n=%h c=%0d",
                     core_nonce, issued_count, held_n + 60'd1, held_c + 32'd1);
        end
    endtask

    task automatic test_stale_tag();
        core_ready = $urandom_range(0, 1);
        res_valid = 1; res_match = 1; res_tag = 2'd0; res_nonce = rand60();
        tick();
        checks++;
        if (golden_nonce_found !== 1'b0 || core_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stale_tag: got found=%b valid=%b expected found=0 valid=1",
                     golden_nonce_found, core_valid);
        end
        res_match = 0; res_tag = 2'd1;
        tick();
        checks++;
        if (golden_nonce_found !== 1'b0) begin
            failures++;
            $display("[TB] FAIL no_match: got found=%b expected 0", golden_nonce_found);
        end
        res_valid = 0;
    endtask

    task automatic test_golden();
        core_ready = 1;
        res_valid = 1; res_match = 1; res_tag = 2'd1; res_nonce = 60'h123;
        tick();
        res_valid = 0;
        checks++;
        if ({golden_nonce_found, golden_nonce, core_valid, busy} !== {1'b1, 60'h123, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL golden_hit: got f=%b g=%h v=%b b=%b expected f=1 g=123 v=0 b=0",
                     golden_nonce_found, golden_nonce, core_valid, busy);
        end
        checks++;
        if (obs_vec !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL golden_model: got %h expected %h", obs_vec, exp_vec());
        end
        res_valid = 1; res_nonce = 60'h456;
        tick();
        res_valid = 0;
        tick();
        checks++;
        if (golden_nonce !== 60'h123 || obs_vec !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL golden_keep: got %h expected 123", golden_nonce);
        end
    endtask

    task automatic test_collision();
        start_job(rand60() >> 4);
        res_valid = 1; res_match = 1; res_tag = 2'd1; res_nonce = rand60();
        tick();
        set_idle();
        checks++;
        if ({golden_nonce_found, core_tag, core_valid} !== {1'b0, 2'd2, 1'b1} || golden_nonce !== '0) begin
            failures++;
            $display("[TB] FAIL collision: got f=%b t=%0d v=%b g=%h expected f=0 t=2 v=1 g=0",
                     golden_nonce_found, core_tag, core_valid, golden_nonce);
        end
    endtask

    task automatic test_carry_and_find();
        start_job(60'hFFF_FFFF_FFFF_FFFF);
        tick();
        new_work = 0;
        core_ready = 1;
        res_valid = 1; res_match = 1; res_tag = 2'd3; res_nonce = 60'hABC;
        tick();
        set_idle();
        checks++;
        if ({exhausted, golden_nonce_found, golden_nonce, core_valid, issued_count}
            !== {1'b1, 1'b1, 60'hABC, 1'b0, 32'd1}) begin
            failures++;
            $display("[TB] FAIL carry_find: got e=%b f=%b g=%h v=%b c=%0d expected e=1 f=1 g=abc v=0 c=1",
                     exhausted, golden_nonce_found, golden_nonce, core_valid, issued_count);
        end
        // Tag wraps to 0; a hit arriving after exhaustion is still captured
        start_job(60'hFFF_FFFF_FFFF_FFFF);
        core_ready = 1;
        tick();
        new_work = 0;
        tick();
        core_ready = 0;
        res_valid = 1; res_match = 1; res_tag = 2'd0; res_nonce = 60'h5A5;
        tick();
        set_idle();
        checks++;
        if ({core_tag, exhausted, golden_nonce_found, golden_nonce, busy}
            !== {2'd0, 1'b1, 1'b1, 60'h5A5, 1'b0}) begin
            failures++;
            $display("[TB] FAIL done_capture: got t=%0d e=%b f=%b g=%h b=%b expected t=0 e=1 f=1 g=5a5 b=0",
                     core_tag, exhausted, golden_nonce_found, golden_nonce, busy);
        end
        checks++;
        if (obs_vec !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL done_model: got %h expected %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            new_work = ($urandom_range(0, 39) == 0);
            if (new_work) begin
                if ($urandom_range(0, 1) == 1) start_job(60'(NONCE_SPACE - 64'($urandom_range(1, 20))));
                else start_job(rand60());
            end
            core_ready = $urandom_range(0, 1);
            res_valid  = ($urandom_range(0, 2) == 0);
            res_match  = $urandom_range(0, 1);
            res_tag    = ($urandom_range(0, 1) == 1) ? m_tag : 2'($urandom_range(0, 3));
            res_nonce  = rand60();
            tick();
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                errs++;
                if (errs <= 5)
                    $display("[TB] FAIL random%0d: got %h expected %h", i, obs_vec, exp_vec());
            end
        end
        set_idle();
    endtask

    task automatic test_exhaust_step4();
        new_work4 = 1;
        start_nonce4 = 60'hFFF_FFFF_FFFF_FFF8;
        core_ready4 = 1;
        tick();
        new_work4 = 0;
        checks++;
        if (core_valid4 !== 1'b1 || core_nonce4 !== 60'hFFF_FFFF_FFFF_FFF8) begin
            failures++;
            $display("[TB] FAIL step4_first: got v=%b n=%h expected v=1 n=ffffffffffffff8", core_valid4, core_nonce4);
        end
        tick();
        checks++;
        if (core_valid4 !== 1'b1 || core_nonce4 !== 60'hFFF_FFFF_FFFF_FFFC || issued_count4 !== 32'd1) begin
            failures++;
            $display("[TB] FAIL step4_second: got v=%b n=%h c=%0d expected v=1 n=ffffffffffffffc c=1",
                     core_valid4, core_nonce4, issued_count4);
        end
        tick();
        checks++;
        if ({core_valid4, exhausted4, busy4, issued_count4} !== {1'b0, 1'b1, 1'b0, 32'd2}) begin
            failures++;
            $display("[TB] FAIL step4_done: got v=%b e=%b b=%b c=%0d expected v=0 e=1 b=0 c=2",
                     core_valid4, exhausted4, busy4, issued_count4);
        end
        core_ready4 = 0;
    endtask

    task automatic test_reset_midrun();
        start_job(60'h777);
        core_ready = 1;
        tick();
        new_work = 0;
        tick();
        reset = 1;
        res_valid = 1; res_match = 1; res_tag = m_tag; res_nonce = 60'h999;
        tick();
        reset = 0;
        set_idle();
        checks++;
        if (obs_vec !== '0 || obs_vec !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL reset_midrun: got %h expected 0", obs_vec);
        end
        tick();
        checks++;
        if (core_valid !== 1'b0 || busy !== 1'b0 || golden_nonce_found !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle: got v=%b b=%b f=%b expected 0/0/0", core_valid, busy, golden_nonce_found);
        end
    endtask

    // Test sequence
    initial begin
        checks = 0;
        failures = 0;
        reset = 1;
        set_idle();
        start_nonce = '0; start_nonce4 = '0; fixed_data = '0; target_hash = '0;
        @(negedge hash_clk);
        test_reset();
        test_sequence();
        test_stall();
        test_stale_tag();
        test_golden();
        test_collision();
        test_carry_and_find();
        test_random();
        test_exhaust_step4();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
